// File: rtl/signature_analyzer.sv
// -----------------------------------------------------------------------------
// signature_analyzer
//   Serial signature register (LFSR-style compactor) for a BIST session.
//   A session starts when Running rises in IDLE. Each COMPACT cycle folds one
//   data_in bit into the signature. BIST_END closes the session. One CHECK
//   cycle then compares signature and bit count against GOLDEN/EXP_LEN.
//   The block then parks in WAIT_LOW until Running drops, so a lingering
//   Running cannot start a second session.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   Running    in   1      session active (from BIST controller)
//   BIST_END   in   1      session complete (from BIST controller)
//   data_in    in   1      serial response of the circuit under test
//   signature  out  SIG_W  current signature register
//   bit_count  out  16     bits compacted this session (saturating)
//   Done       out  1      one-cycle pulse when the verdict becomes valid
//   Pass       out  1      verdict: signature and length match
//   Fail       out  1      verdict: mismatch
//   Aborted    out  1      Running dropped before BIST_END
// -----------------------------------------------------------------------------
module signature_analyzer #(
    parameter int                SIG_W   = 8,
    parameter logic [SIG_W-1:0]  POLY    = 8'h07,
    parameter logic [SIG_W-1:0]  SEED    = 8'hFF,
    parameter logic [SIG_W-1:0]  GOLDEN  = 8'hF6,
    parameter logic [15:0]       EXP_LEN = 16'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Running,
    input  logic             BIST_END,
    input  logic             data_in,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      bit_count,
    output logic             Done,
    output logic             Pass,
    output logic             Fail,
    output logic             Aborted
);

    typedef enum logic [1:0] {IDLE, COMPACT, CHECK, WAIT_LOW} state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             abort_q, abort_d;

    // Shift left; feed back POLY when the outgoing MSB disagrees with the input bit.
    function automatic logic [SIG_W-1:0] step(input logic [SIG_W-1:0] s, input logic d);
        return {s[SIG_W-2:0], 1'b0} ^ ((s[SIG_W-1] ^ d) ? POLY : '0);
    endfunction

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= 16'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (Running) state_d = COMPACT;
            // BIST_END wins over Running in the same cycle.
            COMPACT:  if (BIST_END) state_d = CHECK;
                      else if (!Running) state_d = IDLE;
            CHECK:    state_d = WAIT_LOW;
            WAIT_LOW: if (!Running) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (Running) begin
                    // The first bit is compacted on the entry edge itself.
                    sig_d   = step(SEED, data_in);
                    cnt_d   = 16'd1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    abort_d = 1'b0;
                end
            end
            COMPACT: begin
                if (!BIST_END) begin
                    if (Running) begin
                        sig_d = step(sig_q, data_in);
                        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    end else begin
                        abort_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                pass_d = (sig_q == GOLDEN) && (cnt_q == EXP_LEN);
                fail_d = !((sig_q == GOLDEN) && (cnt_q == EXP_LEN));
                done_d = 1'b1;
            end
            default: ;  // WAIT_LOW holds everything
        endcase
    end

    assign signature = sig_q;
    assign bit_count = cnt_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign Fail      = fail_q;
    assign Aborted   = abort_q;

endmodule

// File: tb/tb_signature_analyzer.sv
// Directed bench for signature_analyzer. Expected signatures are worked by hand
// from step(s,d) = {s<<1} ^ (s[7]^d ? 07 : 00) starting at FF.
module tb_signature_analyzer;

    logic        clk = 1'b0;
    logic        reset, Running, BIST_END, data_in;
    logic [7:0]  signature, sig2;
    logic [15:0] bit_count, cnt2;
    logic        Done, Pass, Fail, Aborted;
    logic        done2, pass2, fail2, abort2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    signature_analyzer dut (
        .clk(clk), .reset(reset), .Running(Running), .BIST_END(BIST_END),
        .data_in(data_in), .signature(signature), .bit_count(bit_count),
        .Done(Done), .Pass(Pass), .Fail(Fail), .Aborted(Aborted)
    );

    // 1,0,1,0 ends at EB; this copy treats EB as golden to isolate the length check.
    signature_analyzer #(.GOLDEN(8'hEB)) dut_len (
        .clk(clk), .reset(reset), .Running(Running), .BIST_END(BIST_END),
        .data_in(data_in), .signature(sig2), .bit_count(cnt2),
        .Done(done2), .Pass(pass2), .Fail(fail2), .Aborted(abort2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Running = 1'b0; BIST_END = 1'b0; data_in = 1'b0;
        tick(); tick();
        checks++; if (signature !== 8'hFF) begin failures++; $display("FAIL reset_sig got=%h exp=FF", signature); end
        checks++; if (bit_count !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bit_count); end
        checks++; if ({Done, Pass, Fail, Aborted} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {Done, Pass, Fail, Aborted}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_golden();
        Running = 1'b1; data_in = 1'b1; tick();
        checks++; if (signature !== 8'hFE) begin failures++; $display("FAIL gold_s1 got=%h exp=FE", signature); end
        data_in = 1'b0; tick();
        checks++; if (signature !== 8'hFB) begin failures++; $display("FAIL gold_s2 got=%h exp=FB", signature); end
        data_in = 1'b1; tick();
        checks++; if (signature !== 8'hF6) begin failures++; $display("FAIL gold_s3 got=%h exp=F6", signature); end
        checks++; if (bit_count !== 16'd3) begin failures++; $display("FAIL gold_cnt got=%0d exp=3", bit_count); end
        BIST_END = 1'b1; data_in = 1'b0; tick();
        // BIST_END cycle must not compact.
        checks++; if (signature !== 8'hF6 || Done !== 1'b0) begin failures++; $display("FAIL gold_end got sig=%h done=%b exp F6/0", signature, Done); end
        BIST_END = 1'b0; tick();
        checks++; if ({Done, Pass, Fail} !== 3'b110) begin failures++; $display("FAIL gold_verdict got=%b exp=110", {Done, Pass, Fail}); end
        Running = 1'b0; tick();
        checks++; if ({Done, Pass, Fail} !== 3'b010) begin failures++; $display("FAIL gold_hold got=%b exp=010", {Done, Pass, Fail}); end
        tick();
    endtask

    task automatic test_mismatch();
        int pulses = 0;
        Running = 1'b1; data_in = 1'b1; tick();
        checks++; if (signature !== 8'hFE) begin failures++; $display("FAIL mis_s1 got=%h exp=FE", signature); end
        checks++; if (Pass !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", Pass); end
        tick();
        checks++; if (signature !== 8'hFC) begin failures++; $display("FAIL mis_s2 got=%h exp=FC", signature); end
        tick();
        checks++; if (signature !== 8'hF8) begin failures++; $display("FAIL mis_s3 got=%h exp=F8", signature); end
        BIST_END = 1'b1; tick();
        BIST_END = 1'b0; Running = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Done === 1'b1) pulses++;
        end
        checks++; if ({Pass, Fail} !== 2'b01) begin failures++; $display("FAIL mis_verdict got=%b exp=01", {Pass, Fail}); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL mis_done_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_length();
        Running = 1'b1;
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        checks++; if (sig2 !== 8'hEB || cnt2 !== 16'd4) begin failures++; $display("FAIL len_state got sig=%h cnt=%0d exp EB/4", sig2, cnt2); end
        BIST_END = 1'b1; tick();
        BIST_END = 1'b0; tick();
        checks++; if ({done2, pass2, fail2} !== 3'b101) begin failures++; $display("FAIL len_verdict got=%b exp=101", {done2, pass2, fail2}); end
        checks++; if ({Pass, Fail} !== 2'b01) begin failures++; $display("FAIL len_default_verdict got=%b exp=01", {Pass, Fail}); end
        Running = 1'b0; tick(); tick();
    endtask

    task automatic test_abort();
        Running = 1'b1; data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        Running = 1'b0; data_in = 1'b1; tick();
        checks++; if ({Aborted, Pass, Fail, Done} !== 4'b1000) begin failures++; $display("FAIL abort_flags got=%b exp=1000", {Aborted, Pass, Fail, Done}); end
        checks++; if (signature !== 8'hFB || bit_count !== 16'd2) begin failures++; $display("FAIL abort_frozen got sig=%h cnt=%0d exp FB/2", signature, bit_count); end
        tick(); tick();
        // Still IDLE: nothing moves while Running stays low.
        checks++; if (signature !== 8'hFB || Aborted !== 1'b1 || Done !== 1'b0) begin failures++; $display("FAIL abort_idle got sig=%h ab=%b done=%b exp FB/1/0", signature, Aborted, Done); end
        Running = 1'b1; tick();
        checks++; if (Aborted !== 1'b0 || bit_count !== 16'd1 || signature !== 8'hFE) begin failures++; $display("FAIL abort_restart got ab=%b cnt=%0d sig=%h exp 0/1/FE", Aborted, bit_count, signature); end
        Running = 1'b0; tick(); tick();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        Running = 1'b1; data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        checks++; if (bit_count !== 16'd2) begin failures++; $display("FAIL rmid_pre got=%0d exp=2", bit_count); end
        reset = 1'b1; tick();
        reset = 1'b0; Running = 1'b0;
        checks++; if (signature !== 8'hFF || bit_count !== 16'd0) begin failures++; $display("FAIL rmid_regs got sig=%h cnt=%0d exp FF/0", signature, bit_count); end
        checks++; if ({Done, Pass, Fail, Aborted} !== 4'b0000) begin failures++; $display("FAIL rmid_flags got=%b exp=0000", {Done, Pass, Fail, Aborted}); end
        BIST_END = 1'b1; tick();
        BIST_END = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || {Pass, Fail} !== 2'b00) begin failures++; $display("FAIL rmid_stray_end got pulses=%0d pf=%b exp 0/00", pulses, {Pass, Fail}); end
    endtask

    task automatic test_held_high();
        int bad = 0;
        Running = 1'b1;
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        BIST_END = 1'b1; tick();
        BIST_END = 1'b0; tick();
        checks++; if ({Done, Pass, Fail} !== 3'b110) begin failures++; $display("FAIL held_verdict got=%b exp=110", {Done, Pass, Fail}); end
        for (int i = 0; i < 5; i++) begin
            data_in = i[0];
            BIST_END = (i == 2);
            tick();
            if (Done !== 1'b0 || Pass !== 1'b1 || signature !== 8'hF6 || bit_count !== 16'd3) bad++;
        end
        BIST_END = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL held_wait_low got bad_cycles=%0d exp=0", bad); end
        Running = 1'b0; tick();
        checks++; if (Pass !== 1'b1) begin failures++; $display("FAIL held_idle_pass got=%b exp=1", Pass); end
        Running = 1'b1; data_in = 1'b0; tick();
        checks++; if ({Pass, Fail} !== 2'b00 || bit_count !== 16'd1 || signature !== 8'hF9) begin failures++; $display("FAIL held_new_session got pf=%b cnt=%0d sig=%h exp 00/1/F9", {Pass, Fail}, bit_count, signature); end
        Running = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_length();
        test_abort();
        test_reset_mid();
        test_held_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
